smol_decode_stage: RTL

// Registered RV32I decode/operand stage that sits directly upstream of smolALU.
// - Accepts fetched instructions over a valid/ready handshake and reads the register file.
// - Forwards a same-cycle writeback.
// - Builds op_sel, rs1 and rs2_or_imm in the smolALU encoding.
// - Holds the result in one output register until the execute stage accepts it.

---
 rtl/smol_decode_stage.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/smol_decode_stage.sv
// Registered RV32I decode/operand stage feeding smolALU.
// Latency: 1 cycle from capture to out_valid; single output register, no skid buffer.
// Backpressure: in_ready = !out_valid | out_ready; outputs hold while out_valid & !out_ready.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        fetch handshake carrying in_instr and in_pc
//   flush                    kills the held entry and drops the entry being offered
//   rf_raddr*/rf_rdata*      same-cycle register file read ports
//   wb_we/wb_rd/wb_data      same-cycle writeback, forwarded onto the operands
//   out_valid/out_ready      execute handshake; out_* carry the decoded entry
module smol_decode_stage #(
    parameter int unsigned PC_W   = 5,
    parameter logic [4:0]  ILL_OP = 5'd31
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [31:0]     rf_rdata1,
    input  logic [31:0]     rf_rdata2,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [31:0]     wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_op_sel,
    output logic [31:0]     out_rs1,
    output logic [31:0]     out_rs2_or_imm,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_is_branch,
    output logic [2:0]      out_funct3,
    output logic [31:0]     out_store_data,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Output register
    logic            r_valid;
    logic [4:0]      r_op_sel;
    logic [31:0]     r_rs1;
    logic [31:0]     r_rs2_or_imm;
    logic [PC_W-1:0] r_pc;
    logic [4:0]      r_rd;
    logic            r_rd_we;
    logic            r_is_load;
    logic            r_is_store;
    logic            r_is_branch;
    logic [2:0]      r_funct3;
    logic [31:0]     r_store_data;
    logic            r_illegal;

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1_idx;
    logic [4:0]  w_rs2_idx;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    // Decode results
    logic [4:0]  w_op_sel;
    logic [31:0] w_opa;
    logic [31:0] w_opb;
    logic [31:0] w_sdata;
    logic        w_legal;
    logic        w_writes;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_branch;
    logic [4:0]  w_alu_op;
    logic        w_capture;

    assign w_opcode  = in_instr[6:0];
    assign w_rd      = in_instr[11:7];
    assign w_funct3  = in_instr[14:12];
    assign w_rs1_idx = in_instr[19:15];
    assign w_rs2_idx = in_instr[24:20];
    assign w_funct7  = in_instr[31:25];

    assign rf_raddr1 = w_rs1_idx;
    assign rf_raddr2 = w_rs2_idx;

    // x0 is forced to zero before the bypass check, so a writeback aimed at
    // x0 can never leak into an operand.
    assign w_rs1_val = (w_rs1_idx == 5'd0)                 ? 32'd0   :
                       (wb_we && (wb_rd == w_rs1_idx))     ? wb_data : rf_rdata1;
    assign w_rs2_val = (w_rs2_idx == 5'd0)                 ? 32'd0   :
                       (wb_we && (wb_rd == w_rs2_idx))     ? wb_data : rf_rdata2;

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'b0};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};

    // funct3 -> smolALU op for the base (non-alternate) ALU operations.
    always_comb begin
        w_alu_op = 5'd0;
        unique case (w_funct3)
            3'b000: w_alu_op = 5'd0;   // add
            3'b001: w_alu_op = 5'd6;   // sll
            3'b010: w_alu_op = 5'd11;  // slt
            3'b011: w_alu_op = 5'd7;   // sltu
            3'b100: w_alu_op = 5'd4;   // xor
            3'b101: w_alu_op = 5'd5;   // srl
            3'b110: w_alu_op = 5'd3;   // or
            3'b111: w_alu_op = 5'd2;   // and
            default: w_alu_op = 5'd0;
        endcase
    end

    always_comb begin
        w_op_sel    = ILL_OP;
        w_opa       = 32'd0;
        w_opb       = 32'd0;
        w_sdata     = 32'd0;
        w_legal     = 1'b1;
        w_writes    = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_branch = 1'b0;
        unique case (w_opcode)
            OPC_OP: begin
                w_opa    = w_rs1_val;
                w_opb    = w_rs2_val;
                w_writes = 1'b1;
                if (w_funct7 == F7_BASE) begin
                    w_op_sel = w_alu_op;
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
                    w_op_sel = 5'd1;   // sub
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
                    w_op_sel = 5'd12;  // sra
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                w_opa    = w_rs1_val;
                w_opb    = w_imm_i;     // shifts keep the full I-imm; ALU uses [4:0]
                w_writes = 1'b1;
                if (w_funct3 != 3'b101) begin
                    w_op_sel = w_alu_op;
                end else if (w_funct7 == F7_BASE) begin
                    w_op_sel = 5'd5;   // srli
                end else if (w_funct7 == F7_ALT) begin
                    w_op_sel = 5'd12;  // srai
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_LOAD: begin
                w_op_sel  = 5'd13;
                w_opa     = w_rs1_val;
                w_opb     = w_imm_i;
                w_writes  = 1'b1;
                w_is_load = 1'b1;
                if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) begin
                    w_legal = 1'b0;
                end
            end
            OPC_STORE: begin
                w_op_sel   = 5'd13;
                w_opa      = w_rs1_val;
                w_opb      = w_imm_s;
                w_sdata    = w_rs2_val;
                w_is_store = 1'b1;
            end
            OPC_BRANCH: begin
                // ALU compares via sub; the branch offset rides on store_data.
                w_op_sel    = 5'd1;
                w_opa       = w_rs1_val;
                w_opb       = w_rs2_val;
                w_sdata     = w_imm_b;
                w_is_branch = 1'b1;
            end
            OPC_LUI: begin
                w_op_sel = 5'd8;
                w_opb    = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_AUIPC: begin
                w_op_sel = 5'd9;
                w_opb    = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_JAL: begin
                w_op_sel = 5'd10;
                w_sdata  = w_imm_j;
                w_writes = 1'b1;
            end
            OPC_JALR: begin
                w_op_sel = 5'd10;
                w_opa    = w_rs1_val;
                w_sdata  = w_imm_i;
                w_writes = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase

        // Illegal entries still flow, but carry no side effects.
        if (!w_legal) begin
            w_op_sel    = ILL_OP;
            w_opa       = 32'd0;
            w_opb       = 32'd0;
            w_sdata     = 32'd0;
            w_writes    = 1'b0;
            w_is_load   = 1'b0;
            w_is_store  = 1'b0;
            w_is_branch = 1'b0;
        end
    end

    assign in_ready  = !r_valid || out_ready;
    // A flushed offer is dropped here; fetch still sees in_ready and treats it as consumed.
    assign w_capture = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_op_sel     <= ILL_OP;
            r_rs1        <= 32'd0;
            r_rs2_or_imm <= 32'd0;
            r_pc         <= '0;
            r_rd         <= 5'd0;
            r_rd_we      <= 1'b0;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_is_branch  <= 1'b0;
            r_funct3     <= 3'd0;
            r_store_data <= 32'd0;
            r_illegal    <= 1'b0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid      <= 1'b1;
                r_op_sel     <= w_op_sel;
                r_rs1        <= w_opa;
                r_rs2_or_imm <= w_opb;
                r_pc         <= in_pc;
                r_rd         <= w_rd;
                r_rd_we      <= w_legal && w_writes && (w_rd != 5'd0);
                r_is_load    <= w_is_load;
                r_is_store   <= w_is_store;
                r_is_branch  <= w_is_branch;
                r_funct3     <= w_funct3;
                r_store_data <= w_sdata;
                r_illegal    <= !w_legal;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid      = r_valid;
    assign out_op_sel     = r_op_sel;
    assign out_rs1        = r_rs1;
    assign out_rs2_or_imm = r_rs2_or_imm;
    assign out_pc         = r_pc;
    assign out_rd         = r_rd;
    assign out_rd_we      = r_rd_we;
    assign out_is_load    = r_is_load;
    assign out_is_store   = r_is_store;
    assign out_is_branch  = r_is_branch;
    assign out_funct3     = r_funct3;
    assign out_store_data = r_store_data;
    assign out_illegal    = r_illegal;

endmodule
